// File: rtl/hamory_pkg.sv
// rtl/hamory_pkg.sv - shared constants and enums for the object-cell sequencer
package hamory_pkg;

  localparam int ADDR_WIDTH = 64;
  localparam int HNDL_WIDTH = 8;
  localparam int NUM_CELLS  = 4;
  localparam int DATA_WIDTH = ADDR_WIDTH - HNDL_WIDTH - 1;

  typedef enum logic [1:0] {
    OP_ALLOC  = 2'd0,
    OP_FREE   = 2'd1,
    OP_LOOKUP = 2'd2,
    OP_REMAP  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK         = 2'd0,
    ST_FULL       = 2'd1,
    ST_BAD_HANDLE = 2'd2,
    ST_MISMATCH   = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    IDLE      = 3'd1,
    ALLOC_ID  = 3'd2,
    ALLOC_MAP = 3'd3,
    FREE      = 3'd4,
    REMAP     = 3'd5,
    LOOKUP    = 3'd6,
    RESP      = 3'd7
  } state_e;

endpackage

// File: rtl/handle_bitmap.sv
// rtl/handle_bitmap.sv - shadow valid bits for each cell plus population counter
module handle_bitmap #(
  parameter int HNDL_WIDTH = 8,
  parameter int NUM_CELLS  = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  set_en,
  input  logic [HNDL_WIDTH-1:0] set_idx,
  input  logic                  clr_en,
  input  logic [HNDL_WIDTH-1:0] clr_idx,
  input  logic [HNDL_WIDTH-1:0] test_idx,
  output logic                  test_bit,
  output logic [HNDL_WIDTH:0]   count
);

  // Index width into the bit vector; the vector is padded to a power of two
  // so a truncated index never selects outside it. Pad bits stay zero.
  localparam int IW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
  localparam logic [HNDL_WIDTH:0] CELLS = (HNDL_WIDTH+1)'(NUM_CELLS);
  localparam logic [HNDL_WIDTH:0] ONE   = (HNDL_WIDTH+1)'(1);

  logic [(1<<IW)-1:0] bits;

  function automatic logic in_range(input logic [HNDL_WIDTH-1:0] idx);
    return {1'b0, idx} < CELLS;
  endfunction

  // Test port: out-of-range handles always read as not valid
  always_comb begin
    test_bit = in_range(test_idx) && bits[test_idx[IW-1:0]];
  end

  // Set/clear only move the count when the bit actually changes, so it cannot drift
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bits  <= '0;
      count <= '0;
    end else if (set_en && in_range(set_idx) && !bits[set_idx[IW-1:0]]) begin
      bits[set_idx[IW-1:0]] <= 1'b1;
      count                 <= count + ONE;
    end else if (clr_en && in_range(clr_idx) && bits[clr_idx[IW-1:0]]) begin
      bits[clr_idx[IW-1:0]] <= 1'b0;
      count                 <= count - ONE;
    end
  end

endmodule

// File: rtl/object_table_ctrl.sv
// rtl/object_table_ctrl.sv - request sequencer and sole master of the object-cell bus
module object_table_ctrl #(
  parameter int ADDR_WIDTH = hamory_pkg::ADDR_WIDTH,
  parameter int HNDL_WIDTH = hamory_pkg::HNDL_WIDTH,
  parameter int NUM_CELLS  = hamory_pkg::NUM_CELLS,
  localparam int DW        = ADDR_WIDTH - HNDL_WIDTH - 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [HNDL_WIDTH-1:0] req_handle,
  input  logic [DW-1:0]         req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [1:0]            resp_status,
  output logic [HNDL_WIDTH-1:0] resp_handle,
  output logic [DW-1:0]         resp_addr,
  output logic [HNDL_WIDTH-1:0] bus_cs,
  output logic [DW-1:0]         bus_data_out,
  input  logic [DW-1:0]         bus_data_in,
  output logic                  bus_write_to_map,
  output logic                  bus_get_available_id,
  output logic                  bus_write_invalid,
  output logic                  bus_read_address,
  output logic [HNDL_WIDTH:0]   alloc_count
);

  import hamory_pkg::*;

  localparam logic [HNDL_WIDTH:0] CELLS = (HNDL_WIDTH+1)'(NUM_CELLS);
  localparam logic [HNDL_WIDTH:0] ONE   = (HNDL_WIDTH+1)'(1);
  localparam logic [DW-1:0]       ONES  = '1;

  state_e                state_q, state_d;
  logic [HNDL_WIDTH:0]   sweep_q, sweep_d;
  logic [HNDL_WIDTH-1:0] handle_q, id_q;
  logic [DW-1:0]         addr_q;
  logic                  latch_req;

  logic                  req_ready_d, resp_valid_d;
  logic [1:0]            resp_status_d;
  logic [HNDL_WIDTH-1:0] resp_handle_d, cs_d;
  logic [DW-1:0]         resp_addr_d, data_d;
  logic                  wtm_d, gai_d, wi_d, ra_d;

  logic                  bm_set, bm_clr, bm_test_bit, id_ok;
  logic [HNDL_WIDTH-1:0] bm_test_idx;

  // The bitmap is probed with the request handle at accept and with the
  // cell-reported id during allocation; those never overlap.
  assign bm_test_idx = (state_q == IDLE) ? req_handle : id_q;
  assign id_ok       = ({1'b0, id_q} < CELLS) && !bm_test_bit;

  handle_bitmap #(
    .HNDL_WIDTH (HNDL_WIDTH),
    .NUM_CELLS  (NUM_CELLS)
  ) u_bitmap (
    .clock    (clock),
    .reset_n  (reset_n),
    .set_en   (bm_set),
    .set_idx  (id_q),
    .clr_en   (bm_clr),
    .clr_idx  (handle_q),
    .test_idx (bm_test_idx),
    .test_bit (bm_test_bit),
    .count    (alloc_count)
  );

  // Next state plus next values of every registered output; bus strobes are
  // computed on entry to a state so they are visible for exactly that state's cycle.
  always_comb begin
    state_d       = state_q;
    sweep_d       = sweep_q;
    latch_req     = 1'b0;
    req_ready_d   = 1'b0;
    resp_valid_d  = resp_valid;
    resp_status_d = resp_status;
    resp_handle_d = resp_handle;
    resp_addr_d   = resp_addr;
    cs_d          = '0;
    data_d        = ONES;
    wtm_d         = 1'b0;
    gai_d         = 1'b0;
    wi_d          = 1'b0;
    ra_d          = 1'b0;
    bm_set        = 1'b0;
    bm_clr        = 1'b0;

    case (state_q)
      INIT: begin
        if (sweep_q == CELLS) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end else begin
          cs_d    = sweep_q[HNDL_WIDTH-1:0];
          wi_d    = 1'b1;
          sweep_d = sweep_q + ONE;
        end
      end

      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready) begin
          latch_req     = 1'b1;
          req_ready_d   = 1'b0;
          resp_handle_d = req_handle;
          resp_addr_d   = '0;
          case (op_e'(req_op))
            OP_ALLOC: begin
              if (alloc_count == CELLS) begin
                state_d       = RESP;
                resp_valid_d  = 1'b1;
                resp_status_d = ST_FULL;
                resp_handle_d = '0;
              end else begin
                state_d = ALLOC_ID;
                gai_d   = 1'b1;
              end
            end
            default: begin
              if (!bm_test_bit) begin
                state_d       = RESP;
                resp_valid_d  = 1'b1;
                resp_status_d = ST_BAD_HANDLE;
              end else if (op_e'(req_op) == OP_FREE) begin
                state_d = FREE;
                cs_d    = req_handle;
                wi_d    = 1'b1;
              end else if (op_e'(req_op) == OP_LOOKUP) begin
                state_d = LOOKUP;
                cs_d    = req_handle;
                ra_d    = 1'b1;
              end else begin
                state_d = REMAP;
                cs_d    = req_handle;
                data_d  = req_addr;
                wtm_d   = 1'b1;
              end
            end
          endcase
        end
      end

      ALLOC_ID: begin
        state_d = ALLOC_MAP;
        if (id_ok) begin
          cs_d   = id_q;
          data_d = addr_q;
          wtm_d  = 1'b1;
        end
      end

      ALLOC_MAP: begin
        state_d       = RESP;
        resp_valid_d  = 1'b1;
        resp_handle_d = id_q;
        resp_addr_d   = '0;
        if (id_ok) begin
          bm_set        = 1'b1;
          resp_status_d = ST_OK;
        end else begin
          resp_status_d = ST_MISMATCH;
        end
      end

      FREE: begin
        bm_clr        = 1'b1;
        state_d       = RESP;
        resp_valid_d  = 1'b1;
        resp_status_d = ST_OK;
      end

      REMAP: begin
        state_d       = RESP;
        resp_valid_d  = 1'b1;
        resp_status_d = ST_OK;
      end

      LOOKUP: begin
        state_d       = RESP;
        resp_valid_d  = 1'b1;
        resp_status_d = ST_OK;
        resp_addr_d   = bus_data_in;
      end

      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end

      default: state_d = INIT;
    endcase
  end

  // State, latched request operands and all registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q              <= INIT;
      sweep_q              <= '0;
      handle_q             <= '0;
      addr_q               <= '0;
      req_ready            <= 1'b0;
      resp_valid           <= 1'b0;
      resp_status          <= ST_OK;
      resp_handle          <= '0;
      resp_addr            <= '0;
      bus_cs               <= '0;
      bus_data_out         <= ONES;
      bus_write_to_map     <= 1'b0;
      bus_get_available_id <= 1'b0;
      bus_write_invalid    <= 1'b0;
      bus_read_address     <= 1'b0;
    end else begin
      state_q              <= state_d;
      sweep_q              <= sweep_d;
      req_ready            <= req_ready_d;
      resp_valid           <= resp_valid_d;
      resp_status          <= resp_status_d;
      resp_handle          <= resp_handle_d;
      resp_addr            <= resp_addr_d;
      bus_cs               <= cs_d;
      bus_data_out         <= data_d;
      bus_write_to_map     <= wtm_d;
      bus_get_available_id <= gai_d;
      bus_write_invalid    <= wi_d;
      bus_read_address     <= ra_d;
      if (latch_req) begin
        handle_q <= req_handle;
        addr_q   <= req_addr;
      end
    end
  end

  // The cell answers get_available_id and commits its valid bit on the falling
  // edge, so the id is captured on that same edge while the answer is still driven.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      id_q <= '0;
    end else if (state_q == ALLOC_ID) begin
      id_q <= bus_data_in[HNDL_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_object_table_ctrl.sv
// tb/tb_object_table_ctrl.sv - directed scoreboard bench for object_table_ctrl with a cell-array model
module tb_object_table_ctrl;
  import hamory_pkg::*;

  localparam int HW = 8;
  localparam int NC = 4;
  localparam int DW = 55;

  logic          clock, reset_n;
  logic          req_valid, req_ready;
  logic [1:0]    req_op;
  logic [HW-1:0] req_handle;
  logic [DW-1:0] req_addr;
  logic          resp_valid, resp_ready;
  logic [1:0]    resp_status;
  logic [HW-1:0] resp_handle;
  logic [DW-1:0] resp_addr;
  logic [HW-1:0] bus_cs;
  logic [DW-1:0] bus_data_out, bus_data_in;
  logic          bus_write_to_map, bus_get_available_id, bus_write_invalid, bus_read_address;
  logic [HW:0]   alloc_count;

  typedef struct {
    logic [1:0]    status;
    logic [HW-1:0] handle;
    logic [DW-1:0] addr;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   cmp_cnt = 0;
  int   fail_cnt = 0;
  int   strobe_cnt = 0;
  int   multi_cnt = 0;
  int   s0;

  logic          cell_valid [NC];
  logic [DW-1:0] cell_addr  [NC];

  object_table_ctrl dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_op               (req_op),
    .req_handle           (req_handle),
    .req_addr             (req_addr),
    .resp_valid           (resp_valid),
    .resp_ready           (resp_ready),
    .resp_status          (resp_status),
    .resp_handle          (resp_handle),
    .resp_addr            (resp_addr),
    .bus_cs               (bus_cs),
    .bus_data_out         (bus_data_out),
    .bus_data_in          (bus_data_in),
    .bus_write_to_map     (bus_write_to_map),
    .bus_get_available_id (bus_get_available_id),
    .bus_write_invalid    (bus_write_invalid),
    .bus_read_address     (bus_read_address),
    .alloc_count          (alloc_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cells start out claiming to be valid: only the sweep makes them usable
  initial begin
    for (int i = 0; i < NC; i++) begin
      cell_valid[i] = 1'b1;
      cell_addr[i]  = '0;
    end
  end

  // Triand bus: controller value AND-ed with whatever the cells drive
  always_comb begin
    logic found;
    found       = 1'b0;
    bus_data_in = bus_data_out;
    if (bus_get_available_id) begin
      for (int i = 0; i < NC; i++) begin
        if (!found && !cell_valid[i]) begin
          bus_data_in = bus_data_in & DW'(i);
          found       = 1'b1;
        end
      end
    end
    if (bus_read_address && bus_cs < HW'(NC))
      bus_data_in = bus_data_in & cell_addr[bus_cs[1:0]];
  end

  // Cells commit on the falling edge
  always @(negedge clock) begin
    if (bus_get_available_id) begin
      for (int i = 0; i < NC; i++) begin
        if (!cell_valid[i] && (i == 0 || (cell_valid[0] && (i == 1 || (cell_valid[1] && (i == 2 || cell_valid[2]))))))
          cell_valid[i] <= 1'b1;
      end
    end
    if (bus_write_to_map && bus_cs < HW'(NC)) begin
      cell_addr[bus_cs[1:0]]  <= bus_data_out;
      cell_valid[bus_cs[1:0]] <= 1'b1;
    end
    if (bus_write_invalid && bus_cs < HW'(NC))
      cell_valid[bus_cs[1:0]] <= 1'b0;
  end

  // Strobe activity monitor
  always @(posedge clock) begin
    int n;
    n = int'(bus_write_to_map) + int'(bus_get_available_id) + int'(bus_write_invalid) + int'(bus_read_address);
    if (n > 0) strobe_cnt++;
    if (n > 1) multi_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_sweep();
    for (int k = 0; k < NC; k++) begin
      @(posedge clock); #1;
      check("sweep_wi", 64'(bus_write_invalid), 64'd1);
      check("sweep_cs", 64'(bus_cs), 64'(k));
      check("sweep_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clock); #1;
    check("init_ready", 64'(req_ready), 64'd1);
    check("init_wi_off", 64'(bus_write_invalid), 64'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check("req_ready_wait", 64'(req_ready), 64'd1);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [HW-1:0] h, input logic [DW-1:0] a,
                        input logic [1:0] st, input logic [HW-1:0] eh, input logic [DW-1:0] ea,
                        input int lat, input int hold);
    exp_t e;
    int   n;
    wait_ready();
    e = '{status: st, handle: eh, addr: ea, lat: lat};
    sb.push_back(e);
    req_valid  = 1'b1;
    req_op     = op;
    req_handle = h;
    req_addr   = a;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("req_ready_drop", 64'(req_ready), 64'd0);
    n = 1;
    while (!resp_valid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("resp_seen", 64'(resp_valid), 64'd1);
    e = sb.pop_front();
    check("latency", 64'(n), 64'(e.lat));
    check("resp_status", 64'(resp_status), 64'(e.status));
    check("resp_handle", 64'(resp_handle), 64'(e.handle));
    check("resp_addr", 64'(resp_addr), 64'(e.addr));
    repeat (hold) begin
      @(posedge clock); #1;
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_status", 64'(resp_status), 64'(e.status));
      check("hold_handle", 64'(resp_handle), 64'(e.handle));
      check("hold_addr", 64'(resp_addr), 64'(e.addr));
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check("resp_drop", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'd0;
    req_handle = '0;
    req_addr   = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_fields", 64'({resp_status, resp_handle, resp_addr != '0}), 64'd0);
    check("rst_strobes", 64'({bus_write_to_map, bus_get_available_id, bus_write_invalid, bus_read_address}), 64'd0);
    check("rst_cs", 64'(bus_cs), 64'd0);
    check("rst_data_ones", 64'(bus_data_out), {9'd0, {DW{1'b1}}});
    check("rst_count", 64'(alloc_count), 64'd0);

    reset_n = 1'b1;
    check_sweep();

    do_req(OP_ALLOC, 8'd0, 55'h1000, ST_OK, 8'd0, 55'd0, 3, 0);
    check("cell0_addr", 64'(cell_addr[0]), 64'h1000);
    check("count_1", 64'(alloc_count), 64'd1);
    do_req(OP_ALLOC, 8'd0, 55'h1111, ST_OK, 8'd1, 55'd0, 3, 0);
    do_req(OP_ALLOC, 8'd0, 55'h2A0, ST_OK, 8'd2, 55'd0, 3, 0);
    do_req(OP_ALLOC, 8'd0, 55'h3333, ST_OK, 8'd3, 55'd0, 3, 0);
    check("count_4", 64'(alloc_count), 64'd4);

    s0 = strobe_cnt;
    do_req(OP_ALLOC, 8'd0, 55'h4444, ST_FULL, 8'd0, 55'd0, 1, 0);
    check("full_no_strobe", 64'(strobe_cnt), 64'(s0));
    check("count_full", 64'(alloc_count), 64'd4);

    do_req(OP_LOOKUP, 8'd2, 55'd0, ST_OK, 8'd2, 55'h2A0, 2, 0);
    s0 = strobe_cnt;
    do_req(OP_LOOKUP, 8'd7, 55'd0, ST_BAD_HANDLE, 8'd7, 55'd0, 1, 0);
    check("bad_no_strobe", 64'(strobe_cnt), 64'(s0));

    do_req(OP_FREE, 8'd1, 55'd0, ST_OK, 8'd1, 55'd0, 2, 0);
    check("count_free", 64'(alloc_count), 64'd3);
    check("cell1_invalid", 64'(cell_valid[1]), 64'd0);
    do_req(OP_FREE, 8'd1, 55'd0, ST_BAD_HANDLE, 8'd1, 55'd0, 1, 0);
    do_req(OP_ALLOC, 8'd0, 55'h55, ST_OK, 8'd1, 55'd0, 3, 0);
    check("count_realloc", 64'(alloc_count), 64'd4);
    check("cell1_addr", 64'(cell_addr[1]), 64'h55);

    do_req(OP_REMAP, 8'd3, 55'h777, ST_OK, 8'd3, 55'd0, 2, 0);
    do_req(OP_LOOKUP, 8'd3, 55'd0, ST_OK, 8'd3, 55'h777, 2, 5);
    do_req(OP_REMAP, 8'd6, 55'h1, ST_BAD_HANDLE, 8'd6, 55'd0, 1, 0);
    do_req(OP_FREE, 8'd0, 55'd0, ST_OK, 8'd0, 55'd0, 2, 0);
    check("count_before_rst", 64'(alloc_count), 64'd3);

    wait_ready();
    req_valid = 1'b1;
    req_op    = OP_ALLOC;
    req_addr  = 55'h999;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("in_alloc_id", 64'(bus_get_available_id), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_count", 64'(alloc_count), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    check("mid_rst_strobes", 64'({bus_write_to_map, bus_get_available_id, bus_write_invalid, bus_read_address}), 64'd0);
    check("mid_rst_resp", 64'(resp_valid), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    check_sweep();
    check("count_after_rst", 64'(alloc_count), 64'd0);

    do_req(OP_ALLOC, 8'd0, 55'hABC, ST_OK, 8'd0, 55'd0, 3, 0);
    check("count_final", 64'(alloc_count), 64'd1);
    check("onehot_strobes", 64'(multi_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
